dmem_responder: RTL
===================

Name: dmem_responder

Overview:
- Data-memory responder for the core's load/store path: executes each load or store request issued on behalf of the execute stage.
- Serves requests from an internal word array after a fixed latency.
- Returns load data left-justified in `rsp_data`, so the addressed byte sits in [31:24] and the addressed halfword in [31:16]. Sign/zero extension is done by the execute stage.
- Reports misaligned, out-of-range and illegal-size requests as faults.

Parameters:
- XLEN, 32, data/address width.
- ADDR_W, 10, word-address width; the array holds 2^ADDR_W words.
- LATENCY, 2, cycles from request acceptance to `rsp_valid`; legal values are 1 to 15.

Ports:
- clk  input  1  clock, rising-edge active.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- req_addr  input  XLEN  byte address.
- req_wdata  input  XLEN  store data; the byte/halfword is taken from the low bits.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_data  output  XLEN  left-justified load data; 0 for stores and faults.
- rsp_fault  output  1  qualifies `rsp_valid`; 1 means the request was not performed.

Behaviour:
- Reset (`reset`=0, asynchronous):
  - State goes to IDLE.
  - `req_ready`=0 while reset is asserted.
  - `rsp_valid`=0, `rsp_data`=0, `rsp_fault`=0, wait counter cleared.
  - Array contents are not cleared.
- State machine IDLE -> WAIT -> RESP -> IDLE:
  - IDLE: `req_ready`=1. On `req_valid`&&`req_ready`, capture we/size/addr/wdata, load the counter with LATENCY-1, then go to WAIT, or directly to RESP if LATENCY=1.
  - WAIT: `req_ready`=0. Counter decrements; at 0, go to RESP.
  - RESP: `rsp_valid`=1 for exactly one cycle, `req_ready`=0; next state IDLE.
- Timing:
  - `rsp_valid` rises exactly LATENCY cycles after the accepting edge.
  - There is no response backpressure.
  - Throughput is one request per LATENCY+1 cycles.
- Fault checks, evaluated on captured values:
  - Size 011, 110 or 111 is a fault.
  - Store with size 100 or 101 is a fault.
  - H/HU with addr[0]=1 is a fault.
  - W with addr[1:0]≠0 is a fault.
  - Any nonzero bit in addr[XLEN-1:ADDR_W+2] is a fault.
  - On a fault: no array write, `rsp_data`=0, `rsp_fault`=1.
- Storage: little-endian within each word; byte k of a word = bits [8k+7:8k], with k=addr[1:0]. Word index = addr[ADDR_W+1:2].
- Loads, with W = the array word read at the RESP-entering edge:
  - B/BU: `rsp_data` = {W byte k, 24'b0}.
  - H/HU: `rsp_data` = {W halfword addr[1], 16'b0}.
  - W: `rsp_data` = W.
- Stores:
  - Byte-enabled write committed on the edge entering RESP; only addressed bytes change.
  - SB writes wdata[7:0] to byte k.
  - SH writes wdata[15:0] to halfword addr[1].
  - `rsp_data`=0, `rsp_fault`=0.
- Ordering:
  - A load accepted after a store's `rsp_valid` observes the stored data.
  - Requests never overlap.
- Asynchronous reset mid-request:
  - Aborts the request; no response is produced.
  - A store whose commit edge has not occurred is dropped.
- `req_valid` held high in WAIT/RESP is not accepted; it is accepted on the first IDLE cycle.
- Outputs `rsp_data`/`rsp_fault` are registered and hold their values between pulses.
- `rsp_valid` is 0 outside RESP.

Test Plan:
- SW addr 0x10 data 0xA1B2C3D4, then LW 0x10 -> first response: `rsp_valid` pulse 2 cycles after accept, `rsp_data`=0, `rsp_fault`=0. LW response: `rsp_data`=0xA1B2C3D4, `rsp_fault`=0.
- After that SW: LB 0x11 -> 0xC3000000; LHU 0x12 -> 0xA1B20000; LBU 0x13 -> 0xA1000000.
- SB addr 0x12 data 0x000000EE, then LW 0x10 -> 0xA1EEC3D4.
- SH addr 0x11 -> `rsp_fault`=1, `rsp_data`=0, and a following LW 0x10 still returns 0xA1EEC3D4.
- LW addr 0x1000 (ADDR_W=10) -> `rsp_fault`=1.
- Size 011 -> `rsp_fault`=1.
- `req_valid` held high continuously with LATENCY=2 -> accepts spaced 3 cycles apart; `req_ready` low in WAIT and RESP.
- Reset deasserted-then-asserted one cycle after accepting SW 0x20 data 0x12345678 -> no `rsp_valid`; after reset release, LW 0x20 does not return 0x12345678 unless that location previously held it.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder: serves one load/store at a time from a byte-laned word
// array, answering after a fixed latency with left-justified load data or a fault.
module dmem_responder #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [2:0]      req_size,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            rsp_valid,
    output logic [XLEN-1:0] rsp_data,
    output logic            rsp_fault
);
    localparam int         NB       = XLEN / 8;
    localparam int         DEPTH    = 2 ** ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [2:0]        size_q, size_d;
    logic [XLEN-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]   wdata_q, wdata_d;
    logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic              commit;

    logic              op_we;
    logic [2:0]        op_size;
    logic [XLEN-1:0]   op_addr;
    logic [XLEN-1:0]   op_wdata;
    logic              fault;
    logic              mem_we;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        byte_k;
    logic [NB-1:0]     lane_be;
    logic [XLEN-1:0]   lane_wr;
    logic [XLEN-1:0]   rd_word;
    logic [XLEN-1:0]   load_data;

    // With LATENCY=1 the commit edge is the accepting edge, so the request is
    // taken straight from the inputs instead of the capture registers.
    assign op_we    = (state_q == S_IDLE) ? req_we    : we_q;
    assign op_size  = (state_q == S_IDLE) ? req_size  : size_q;
    assign op_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    assign op_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;

    assign idx    = op_addr[ADDR_W+1:2];
    assign byte_k = op_addr[1:0];

    assign fault = (op_size inside {3'b011, 3'b110, 3'b111})
                || (op_we && op_size[2])
                || ((op_size[1:0] == 2'b01) && op_addr[0])
                || ((op_size == 3'b010) && (op_addr[1:0] != 2'b00))
                || (|op_addr[XLEN-1:ADDR_W+2]);

    assign mem_we = commit && op_we && !fault;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];

            assign lane_be[gi] = (op_size[1:0] == 2'b00) ? (byte_k == 2'(gi)) :
                                 (op_size[1:0] == 2'b01) ? (op_addr[1] == 1'(gi / 2)) :
                                 1'b1;
            // Narrow stores replicate their low bytes across the lanes.
            assign lane_wr[gi*8 +: 8] = (op_size[1:0] == 2'b00) ? op_wdata[7:0] :
                                        (op_size[1:0] == 2'b01) ? op_wdata[(gi % 2)*8 +: 8] :
                                        op_wdata[gi*8 +: 8];

            always_ff @(posedge clk) begin
                if (mem_we && lane_be[gi]) begin
                    lane_mem[idx] <= lane_wr[gi*8 +: 8];
                end
            end

            assign rd_word[gi*8 +: 8] = lane_mem[idx];
        end
    endgenerate

    always_comb begin
        load_data = rd_word;
        case (op_size[1:0])
            2'b00:   load_data = {rd_word[{byte_k, 3'b000} +: 8], {(XLEN-8){1'b0}}};
            2'b01:   load_data = {rd_word[{op_addr[1], 4'b0000} +: 16], {(XLEN-16){1'b0}}};
            default: load_data = rd_word;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        size_d      = size_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_data_d  = rsp_data_q;
        rsp_fault_d = rsp_fault_q;
        commit      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    we_d    = req_we;
                    size_d  = req_size;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    cnt_d   = CNT_INIT;
                    if (LATENCY == 1) begin
                        state_d = S_RESP;
                        commit  = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0) begin
                    state_d = S_RESP;
                    commit  = 1'b1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (commit) begin
            rsp_fault_d = fault;
            rsp_data_d  = (fault || op_we) ? '0 : load_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            size_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rsp_data_q  <= '0;
            rsp_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            size_q      <= size_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rsp_data_q  <= rsp_data_d;
            rsp_fault_q <= rsp_fault_d;
        end
    end

    assign req_ready = (state_q == S_IDLE) && reset;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_fault = rsp_fault_q;

endmodule
